// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator output path.
package acc_pkg;

  localparam int PIX_W      = 8;
  localparam int POOL_BEATS = 4;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   last;
  } fifo_entry_t;

  function automatic pixel_t signed_max(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_unit_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one wrap bit.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // Full/empty decided by the wrap bit; a full FIFO may still accept a
  // write in the same cycle it is read.
  always_comb begin
    o_empty = (r_wptr == r_rptr);
    o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_do_rd = i_rd_en && !o_empty;
    w_do_wr = i_wr_en && (!o_full || w_do_rd);
    o_dout  = r_mem[r_rptr[AW-1:0]];
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  // Read/write pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/relu_maxpool_unit.sv
// ReLU + 2x2 max-pool reduction of the conv pixel stream with FWFT output FIFO.
module relu_maxpool_unit
  import acc_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_valid_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] conv_result_i,
  input  logic              relu_en_i,
  input  logic              pool_en_i,
  output logic              pool_valid_o,
  input  logic              pool_ready_i,
  output logic [DATA_W-1:0] pool_data_o,
  output logic              pool_last_o,
  output logic              overflow_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int            CW       = $clog2(POOL_BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(POOL_BEATS - 1);

  logic [CW-1:0]  r_cnt;
  pixel_t         r_max;
  logic           r_relu;
  logic           r_pool;
  logic           r_push_vld;
  fifo_entry_t    r_push;
  logic           r_overflow;
  logic           r_frame_err;

  pixel_t         w_x;
  pixel_t         w_v;
  pixel_t         w_max_next;
  logic           w_first;
  logic           w_relu_mode;
  logic           w_pool_mode;
  logic           w_complete;
  logic           w_short_last;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [$bits(fifo_entry_t)-1:0] w_head_bits;
  fifo_entry_t    w_head;

  // Per-beat datapath: modes come live from the inputs on index 0 and
  // from the latches for the rest of the window.
  always_comb begin
    w_x          = conv_result_i;
    w_first      = (r_cnt == '0);
    w_relu_mode  = w_first ? relu_en_i : r_relu;
    w_pool_mode  = w_first ? pool_en_i : r_pool;
    w_v          = (w_relu_mode && w_x[PIX_W-1]) ? '0 : w_x;
    w_max_next   = w_first ? w_v : signed_max(r_max, w_v);
    w_complete   = conv_valid_i && (!w_pool_mode || last_i || (r_cnt == LAST_IDX));
    w_short_last = conv_valid_i && last_i && w_pool_mode && (r_cnt != LAST_IDX);
  end

  // Beat counter, running max and window mode latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_max  <= '0;
      r_relu <= 1'b0;
      r_pool <= 1'b0;
    end else if (conv_valid_i) begin
      r_max <= w_max_next;
      r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_relu <= relu_en_i;
        r_pool <= pool_en_i;
      end
    end
  end

  // Push stage: a completed window is written into the FIFO one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_vld <= 1'b0;
      r_push     <= '0;
    end else begin
      r_push_vld <= w_complete;
      if (w_complete) begin
        r_push.data <= w_max_next;
        r_push.last <= last_i;
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_push_vld && w_full && !w_pop) r_overflow  <= 1'b1;
      if (w_short_last)                   r_frame_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (r_push_vld),
    .i_din   (r_push),
    .i_rd_en (w_pop),
    .o_dout  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output view of the FIFO head; data and last read as 0 while empty
  always_comb begin
    w_head       = fifo_entry_t'(w_head_bits);
    w_pop        = !w_empty && pool_ready_i;
    pool_valid_o = !w_empty;
    pool_data_o  = w_empty ? '0 : w_head.data;
    pool_last_o  = w_empty ? 1'b0 : w_head.last;
    overflow_o   = r_overflow;
    frame_err_o  = r_frame_err;
    busy_o       = (r_cnt != '0) || r_push_vld || !w_empty;
  end

endmodule

// File: doc/relu_maxpool_unit.md
Name: relu_maxpool_unit

Overview:
- Consumer end of the accumulator output interface (conv_valid / last / conv_result).
- Takes the 8-bit saturated conv pixel stream, applies optional ReLU, and reduces each group of 4 consecutive beats (one 2x2 pool window, order p1,p2,p3,p4) to its maximum.
- Buffers results in a FIFO and presents them to the feature-map writer over a valid/ready handshake.
- The upstream interface has no backpressure; this block must accept every beat.

Parameters:
- FIFO_DEPTH, 16, result FIFO entries (power of 2, >=4).
- DATA_W, 8, pixel width (signed two's complement).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- conv_valid_i  in  1  input beat valid.
- last_i  in  1  final beat of the layer; qualified by conv_valid_i.
- conv_result_i  in  DATA_W  signed conv pixel.
- relu_en_i  in  1  1 = clamp negatives to 0. Sampled on the first beat of each window.
- pool_en_i  in  1  1 = 2x2 max-pool; 0 = bypass (each beat is one result). Sampled on the first beat of each window.
- pool_valid_o  out  1  result available.
- pool_ready_i  in  1  downstream accepts.
- pool_data_o  out  DATA_W  result pixel.
- pool_last_o  out  1  marks the final result of the layer.
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full.
- frame_err_o  out  1  sticky: last_i arrived with a partial pool window.
- busy_o  out  1  partial window held, or FIFO non-empty.

Behaviour:
- Reset: all outputs 0; beat counter 0; max register 0; FIFO empty. Sticky flags are cleared only by rst. Reset mid-frame discards partial windows and FIFO contents.
- Beat processing (when conv_valid_i=1):
  - v = (relu_mode && x<0) ? 0 : x, where x is conv_result_i. Signed compare throughout.
  - Beat index 0: max <= v; latch relu_mode and pool_mode.
  - Beat indices 1-3: max <= signed_max(max, v).
- Window completion:
  - Pool mode: completes on beat index 3, then the counter wraps to 0.
  - Bypass mode: every beat completes a window; the counter stays 0.
- FIFO push:
  - Completion registers {result, last_i} into a push stage. The push occurs on the next edge.
  - If the 4th beat is sampled at edge E, the FIFO write happens at edge E+1 and pool_valid_o is 1 after edge E+1, i.e. two cycles of latency.
  - Back-to-back windows are sustained at one beat per cycle.
- last_i handling:
  - last_i on beat index 3 (pool mode) or any beat (bypass) -> result pushed with pool_last_o=1.
  - last_i on beat index 0-2 in pool mode -> frame_err_o set. The partial window is still pushed as the max of the beats received, with last=1; the counter resets to 0.
  - conv_valid_i=0 with last_i=1 is ignored.
- FIFO: first-word-fall-through.
  - pool_valid_o = !empty.
  - pool_data_o and pool_last_o are the head entry; they are stable while valid=1 and ready=0.
  - Pop when pool_valid_o && pool_ready_i.
- FIFO boundaries:
  - Push when full with no pop -> entry dropped, overflow_o set, FIFO unchanged.
  - Push and pop in the same cycle when full -> both succeed.
  - Push and pop in the same cycle when empty -> the pop is a no-op (valid=0); the push lands and valid rises the next cycle. No combinational bypass.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty is decided by MSB comparison; the count wraps naturally.
- A mode change mid-window has no effect until the next index-0 beat.

Decomposition:
- Package acc_pkg:
  - typedef pixel_t (logic signed [DATA_W-1:0]).
  - typedef fifo_entry_t struct {pixel_t data; logic last;}.
  - localparam POOL_BEATS=4.
  - function signed_max.
- Sub-module sync_fifo (parameterised width/depth, FWFT, full/empty outputs). Instantiated once, carrying fifo_entry_t.
- Pooling counter, max register and push stage are in the top.

Test Plan:
1. Pool, ReLU on, ready=1; beats {5,-3,12,7} with last on the 4th -> one result 12, pool_last_o=1, pool_valid_o high exactly 2 cycles after the 4th beat.
2. Pool, ReLU on; beats {-8,-1,-128,-5} -> result 0. Same with ReLU off -> result -1.
3. Bypass, ReLU off; beats {-128,127,0} with last on the 3rd -> results -128,127,0; last only on 0; frame_err_o=0.
4. Pool mode; last on the 2nd beat of {3,9} -> frame_err_o=1, result 9 with last; the next window starts at index 0.
5. FIFO_DEPTH=16, ready=0, 17 pool windows -> 16 stored, overflow_o=1. With ready=1 afterwards, 16 results drain in order, the 17th is absent, and data holds while stalled.
6. FIFO full with ready=1 during a push -> no drop, overflow_o stays 0. Assert rst mid-window -> all outputs 0 the next cycle, and the FIFO is empty.
